// File: rtl/alu_v2_pkg.sv
// Shared op codes and reset constants for the alu_v2 registered ALU.
package alu_v2_pkg;

   localparam logic [2:0] OP_PASS_A = 3'b000;
   localparam logic [2:0] OP_ADD    = 3'b001;
   localparam logic [2:0] OP_SUB    = 3'b010;
   localparam logic [2:0] OP_PASS_B = 3'b011;
   localparam logic [2:0] OP_AND    = 3'b100;
   localparam logic [2:0] OP_OR     = 3'b101;
   localparam logic [2:0] OP_XOR    = 3'b110;
   localparam logic [2:0] OP_NOT_A  = 3'b111;

   // Reset flag values describe a zero result: z set, everything else clear.
   localparam logic RST_CO = 1'b0;
   localparam logic RST_Z  = 1'b1;
   localparam logic RST_N  = 1'b0;
   localparam logic RST_V  = 1'b0;

endpackage

// File: rtl/alu_v2_addsub.sv
// Shared adder for ADD and SUB: SUB inverts b and the carry-in (a + ~b + !ci).
// The overflow output exists only when ALU_V2_FLAGS_EN is defined.
module alu_v2_addsub #(
   parameter int W = 8
) (
   input  logic         sub,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] sum,
   output logic         co
`ifdef ALU_V2_FLAGS_EN
   ,
   output logic         v
`endif
);

   logic [W-1:0] b_eff;
   logic         c_eff;

   assign b_eff = sub ? ~b : b;
   assign c_eff = sub ? ~ci : ci;

   assign {co, sum} = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, c_eff};

`ifdef ALU_V2_FLAGS_EN
   // Same-sign operands producing an opposite-sign sum; b_eff folds the SUB case in.
   assign v = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);
`endif

endmodule

// File: rtl/alu_v2.sv
// W-bit registered ALU with carry/borrow and optional z/n/v flags.
// Flags are generated only when ALU_V2_FLAGS_EN is defined; otherwise they read 0.
module alu_v2
   import alu_v2_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [2:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] y,
   output logic         co,
   output logic         z,
   output logic         n,
   output logic         v
);

   logic [W-1:0] sum;
   logic [W-1:0] y_next;
   logic         add_co;
   logic         co_next;
   logic         is_sub;
   logic         is_arith;

   assign is_sub   = (op == OP_SUB);
   assign is_arith = (op == OP_ADD) || (op == OP_SUB);

`ifdef ALU_V2_FLAGS_EN
   logic add_v;
`endif

   alu_v2_addsub #(.W(W)) u_addsub (
      .sub (is_sub),
      .a   (a),
      .b   (b),
      .ci  (ci),
      .sum (sum),
      .co  (add_co)
`ifdef ALU_V2_FLAGS_EN
      ,
      .v   (add_v)
`endif
   );

   always_comb begin
      y_next = a;
      case (op)
         OP_PASS_A: y_next = a;
         OP_ADD:    y_next = sum;
         OP_SUB:    y_next = sum;
         OP_PASS_B: y_next = b;
         OP_AND:    y_next = a & b;
         OP_OR:     y_next = a | b;
         OP_XOR:    y_next = a ^ b;
         OP_NOT_A:  y_next = ~a;
         default:   y_next = a;
      endcase
   end

   assign co_next = is_arith & add_co;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y  <= '0;
         co <= RST_CO;
      end else begin
         y  <= y_next;
         co <= co_next;
      end
   end

`ifdef ALU_V2_FLAGS_EN
   // Flags come from y_next so they are registered alongside the result they describe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         z <= RST_Z;
         n <= RST_N;
         v <= RST_V;
      end else begin
         z <= (y_next == '0);
         n <= y_next[W-1];
         v <= is_arith & add_v;
      end
   end
`else
   assign z = 1'b0;
   assign n = 1'b0;
   assign v = 1'b0;
`endif

endmodule

// File: tb/tb_alu_v2.sv
// Directed self-checking bench for alu_v2 at W=4; flag expectations follow ALU_V2_FLAGS_EN.
module tb_alu_v2;

   localparam int W = 4;
`ifdef ALU_V2_FLAGS_EN
   localparam logic FE = 1'b1;
`else
   localparam logic FE = 1'b0;
`endif

   logic         clk;
   logic         rst;
   logic [2:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ci;
   logic [W-1:0] y;
   logic         co;
   logic         z;
   logic         n;
   logic         v;

   int checks = 0;
   int errors = 0;

   alu_v2 #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .op  (op),
      .a   (a),
      .b   (b),
      .ci  (ci),
      .y   (y),
      .co  (co),
      .z   (z),
      .n   (n),
      .v   (v)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive at the falling edge, then step past the next rising edge to observe.
   task automatic apply(input logic [2:0] o, input int ia, input int ib, input int ic);
      @(negedge clk);
      op = o;
      a  = ia[W-1:0];
      b  = ib[W-1:0];
      ci = ic[0];
      @(posedge clk);
      #1;
   endtask

   // Arithmetic reference using plain integer math and signed range tests.
   function automatic logic [7:0] model(input int o, input int ia, input int ib, input int ic);
      int r;
      int sr;
      int sa;
      int sb;
      logic [3:0] ry;
      logic rc;
      logic rv;
      sa = (ia > 7) ? ia - 16 : ia;
      sb = (ib > 7) ? ib - 16 : ib;
      rc = 1'b0;
      rv = 1'b0;
      r  = 0;
      case (o)
         0: r = ia;
         1: begin
            r  = ia + ib + ic;
            rc = (r > 15);
            sr = sa + sb + ic;
            rv = (sr > 7) || (sr < -8);
         end
         2: begin
            r  = ia - ib - ic;
            rc = (r >= 0);
            sr = sa - sb - ic;
            rv = (sr > 7) || (sr < -8);
         end
         3: r = ib;
         4: r = ia & ib;
         5: r = ia | ib;
         6: r = ia ^ ib;
         default: r = 15 - ia;
      endcase
      ry = r[3:0];
      return {ry, rc, FE & (ry == 4'd0), FE & ry[3], FE & rv};
   endfunction

   task automatic test_reset();
      logic [7:0] got;
      logic [7:0] exp;
      exp = {4'd0, 1'b0, FE, 1'b0, 1'b0};
      rst = 1'b1; op = 3'b001; a = 4'd5; b = 4'd6; ci = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      got = {y, co, z, n, v};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_hold got=%h exp=%h", got, exp); end
      else $display("reset_hold y=%h co=%b z=%b", y, co, z);
      @(negedge clk);
      rst = 1'b0;
      apply(3'b001, 3, 3, 0);
      got = {y, co, z, n, v};
      exp = {4'd6, 1'b0, 1'b0, 1'b0, 1'b0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_release got=%h exp=%h", got, exp); end
      else $display("reset_release y=%h", y);
      // Asynchronous assertion between edges must clear outputs immediately.
      @(negedge clk);
      rst = 1'b1;
      #2;
      got = {y, co, z, n, v};
      exp = {4'd0, 1'b0, FE, 1'b0, 1'b0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_async got=%h exp=%h", got, exp); end
      else $display("reset_async y=%h z=%b", y, z);
      @(posedge clk);
      #1;
      got = {y, co, z, n, v};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_edge got=%h exp=%h", got, exp); end
      else $display("reset_edge y=%h z=%b", y, z);
      @(negedge clk);
      rst = 1'b0;
      op = 3'b001; a = 4'd1; b = 4'd1; ci = 1'b0;
      @(posedge clk);
      #1;
      got = {y, co, z, n, v};
      exp = {4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_first got=%h exp=%h", got, exp); end
      else $display("reset_first y=%h", y);
   endtask

   // Tables: a, b, ci, y, co, z, n, v (hand-computed).
   task automatic test_add();
      int ta[4] = '{3, 9, 7, 15};
      int tb[4] = '{3, 8, 0, 1};
      int tc[4] = '{0, 0, 1, 0};
      int ty[4] = '{6, 1, 8, 0};
      int tco[4] = '{0, 1, 0, 1};
      int tz[4] = '{0, 0, 0, 1};
      int tn[4] = '{0, 0, 1, 0};
      int tv[4] = '{0, 1, 1, 0};
      logic [7:0] got;
      logic [7:0] exp;
      for (int i = 0; i < 4; i++) begin
         apply(3'b001, ta[i], tb[i], tc[i]);
         got = {y, co, z, n, v};
         exp = {ty[i][3:0], tco[i][0], FE & tz[i][0], FE & tn[i][0], FE & tv[i][0]};
         checks++;
         if (got !== exp) begin errors++; $display("FAIL add_%0d got=%h exp=%h", i, got, exp); end
         else $display("add a=%0d b=%0d ci=%0d y=%h co=%b", ta[i], tb[i], tc[i], y, co);
      end
   endtask

   task automatic test_sub();
      int ta[5] = '{3, 1, 2, 8, 0};
      int tb[5] = '{1, 2, 2, 1, 0};
      int tc[5] = '{0, 0, 0, 0, 1};
      int ty[5] = '{2, 15, 0, 7, 15};
      int tco[5] = '{1, 0, 1, 1, 0};
      int tz[5] = '{0, 0, 1, 0, 0};
      int tn[5] = '{0, 1, 0, 0, 1};
      int tv[5] = '{0, 0, 0, 1, 0};
      logic [7:0] got;
      logic [7:0] exp;
      for (int i = 0; i < 5; i++) begin
         apply(3'b010, ta[i], tb[i], tc[i]);
         got = {y, co, z, n, v};
         exp = {ty[i][3:0], tco[i][0], FE & tz[i][0], FE & tn[i][0], FE & tv[i][0]};
         checks++;
         if (got !== exp) begin errors++; $display("FAIL sub_%0d got=%h exp=%h", i, got, exp); end
         else $display("sub a=%0d b=%0d ci=%0d y=%h co=%b", ta[i], tb[i], tc[i], y, co);
      end
   endtask

   // Tables: op, a, b, y, z, n (co and v always 0; ci=1 must not leak into co).
   task automatic test_logic();
      int to[7] = '{4, 5, 6, 6, 0, 3, 7};
      int ta[7] = '{3, 3, 3, 2, 9, 0, 5};
      int tb[7] = '{1, 1, 1, 2, 0, 12, 0};
      int ty[7] = '{1, 3, 2, 0, 9, 12, 10};
      int tz[7] = '{0, 0, 0, 1, 0, 0, 0};
      int tn[7] = '{0, 0, 0, 0, 1, 1, 1};
      logic [7:0] got;
      logic [7:0] exp;
      for (int i = 0; i < 7; i++) begin
         apply(to[i][2:0], ta[i], tb[i], 1);
         got = {y, co, z, n, v};
         exp = {ty[i][3:0], 1'b0, FE & tz[i][0], FE & tn[i][0], 1'b0};
         checks++;
         if (got !== exp) begin errors++; $display("FAIL logic_%0d got=%h exp=%h", i, got, exp); end
         else $display("logic op=%0d a=%0d b=%0d y=%h", to[i], ta[i], tb[i], y);
      end
   endtask

   task automatic test_back_to_back();
      int ops[5] = '{1, 2, 4, 5, 6};
      int ia;
      int ib;
      int ic;
      logic [7:0] got;
      logic [7:0] exp;
      for (int i = 0; i < 16; i++) begin
         for (int k = 0; k < 5; k++) begin
            ia = i % 4;
            ib = i / 4;
            ic = (i % 3 == 0) ? 1 : 0;
            apply(ops[k][2:0], ia, ib, ic);
            got = {y, co, z, n, v};
            exp = model(ops[k], ia, ib, ic);
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL sweep op=%0d a=%0d b=%0d ci=%0d got=%h exp=%h", ops[k], ia, ib, ic, got, exp);
            end else begin
               $display("sweep op=%0d a=%0d b=%0d ci=%0d y=%h co=%b", ops[k], ia, ib, ic, y, co);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      op = 3'b000;
      a = '0;
      b = '0;
      ci = 1'b0;
      test_reset();
      test_add();
      test_sub();
      test_logic();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
